// File: rtl/alu_cond_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Condition-code encoding and VCNZ flag bit positions shared by
//               the ALU writeback stage and any future branch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [3:0] {
        EQ = 4'h0,
        NE = 4'h1,
        CS = 4'h2,
        CC = 4'h3,
        MI = 4'h4,
        PL = 4'h5,
        VS = 4'h6,
        VC = 4'h7,
        HI = 4'h8,
        LS = 4'h9,
        GE = 4'hA,
        LT = 4'hB,
        GT = 4'hC,
        LE = 4'hD,
        AL = 4'hE,
        NV = 4'hF
    } cond_e;

    localparam int FLAG_V = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_cond_wb_cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : cond_eval
// Description : Pure combinational condition evaluator: (cond, VCNZ) -> pass.
// Revision    : 1.0 - initial release
// ============================================================================
module cond_eval
    import alu_pkg::*;
(
    input  cond_e      i_cond,
    input  logic [3:0] i_flags,
    output logic       o_pass
);

    logic w_v;
    logic w_c;
    logic w_n;
    logic w_z;
    logic w_ge;

    assign w_v  = i_flags[FLAG_V];
    assign w_c  = i_flags[FLAG_C];
    assign w_n  = i_flags[FLAG_N];
    assign w_z  = i_flags[FLAG_Z];
    assign w_ge = (w_n == w_v);

    always_comb begin
        o_pass = 1'b0;
        unique case (i_cond)
            EQ: o_pass = w_z;
            NE: o_pass = ~w_z;
            CS: o_pass = w_c;
            CC: o_pass = ~w_c;
            MI: o_pass = w_n;
            PL: o_pass = ~w_n;
            VS: o_pass = w_v;
            VC: o_pass = ~w_v;
            HI: o_pass = w_c & ~w_z;
            LS: o_pass = ~w_c | w_z;
            GE: o_pass = w_ge;
            LT: o_pass = ~w_ge;
            GT: o_pass = ~w_z & w_ge;
            LE: o_pass = w_z | ~w_ge;
            AL: o_pass = 1'b1;
            NV: o_pass = 1'b0;
            default: o_pass = 1'b0;
        endcase
    end

endmodule : cond_eval
`default_nettype wire

// File: rtl/alu_cond_wb.sv
`default_nettype none
// ============================================================================
// Module      : alu_cond_wb
// Description : ALU result consumer: architectural VCNZ register, condition
//               evaluation and a registered valid/ready writeback stage.
//               Optional macro COND_WB_STATS_EN adds exec/skip counters.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cond_wb
    import alu_pkg::*;
#(
    parameter int N  = 8,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_y,
    input  logic [3:0]    in_flags,
    input  logic [3:0]    in_cond,
    input  logic          in_setf,
    input  logic [RW-1:0] in_rd,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic [RW-1:0] out_rd,
    output logic          out_we,
`ifdef COND_WB_STATS_EN
    output logic [15:0]   exec_cnt,
    output logic [15:0]   skip_cnt,
`endif
    output logic [3:0]    flags_q
);

    logic          r_out_valid;
    logic [N-1:0]  r_out_data;
    logic [RW-1:0] r_out_rd;
    logic          r_out_we;
    logic [3:0]    r_flags;

    logic w_pass;
    logic w_ready;
    logic w_accept;

    cond_eval u_cond_eval (
        .i_cond  (cond_e'(in_cond)),
        .i_flags (r_flags),
        .o_pass  (w_pass)
    );

    // Flush blocks acceptance outright, ahead of any output-side readiness.
    assign w_ready  = ~flush & (~r_out_valid | out_ready);
    assign w_accept = in_valid & w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_rd    <= '0;
            r_out_we    <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_y;
            r_out_rd    <= in_rd;
            r_out_we    <= w_pass;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Condition is evaluated on the pre-update flags, so a squashed op never
    // changes them even when it requests a flag update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= 4'b0000;
        end else if (w_accept && in_setf && w_pass) begin
            r_flags <= in_flags;
        end
    end

`ifdef COND_WB_STATS_EN
    logic [15:0] r_exec_cnt;
    logic [15:0] r_skip_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exec_cnt <= 16'h0000;
            r_skip_cnt <= 16'h0000;
        end else if (w_accept) begin
            if (w_pass) begin
                if (r_exec_cnt != 16'hFFFF) r_exec_cnt <= r_exec_cnt + 16'd1;
            end else begin
                if (r_skip_cnt != 16'hFFFF) r_skip_cnt <= r_skip_cnt + 16'd1;
            end
        end
    end

    assign exec_cnt = r_exec_cnt;
    assign skip_cnt = r_skip_cnt;
`endif

    assign in_ready  = w_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_rd    = r_out_rd;
    assign out_we    = r_out_we;
    assign flags_q   = r_flags;

endmodule : alu_cond_wb
`default_nettype wire

// File: tb/tb_alu_cond_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cond_wb
// Description : Directed scoreboard bench for alu_cond_wb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cond_wb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_y;
    logic [3:0] in_flags;
    logic [3:0] in_cond;
    logic       in_setf;
    logic [2:0] in_rd;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_rd;
    logic       out_we;
    logic [3:0] flags_q;
`ifdef COND_WB_STATS_EN
    logic [15:0] exec_cnt;
    logic [15:0] skip_cnt;
`endif

    alu_cond_wb #(.N(8), .RW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_y      (in_y),
        .in_flags  (in_flags),
        .in_cond   (in_cond),
        .in_setf   (in_setf),
        .in_rd     (in_rd),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .out_we    (out_we),
`ifdef COND_WB_STATS_EN
        .exec_cnt  (exec_cnt),
        .skip_cnt  (skip_cnt),
`endif
        .flags_q   (flags_q)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] rd;
        logic       we;
    } exp_t;

    exp_t       q[$];
    logic       m_ov;
    logic [3:0] m_flags;
    int         m_exec;
    int         m_skip;
    int         n_checks;
    int         n_pass;

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic v, cy, n, z;
        v = f[3]; cy = f[2]; n = f[1]; z = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock of the model: compare on the falling edge, then advance.
    task automatic step();
        logic exp_rdy;
        logic acc;
        logic p;
        @(negedge clk);
        exp_rdy = !flush && (!m_ov || out_ready);
        check("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
        check("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
        check("flags_q", {28'b0, flags_q}, {28'b0, m_flags});
`ifdef COND_WB_STATS_EN
        check("exec_cnt", {16'b0, exec_cnt}, m_exec);
        check("skip_cnt", {16'b0, skip_cnt}, m_skip);
`endif
        if (m_ov && q.size() > 0) begin
            check("out_data", {24'b0, out_data}, {24'b0, q[0].d});
            check("out_rd", {29'b0, out_rd}, {29'b0, q[0].rd});
            check("out_we", {31'b0, out_we}, {31'b0, q[0].we});
            if (flush || out_ready) void'(q.pop_front());
        end
        acc = in_valid && exp_rdy;
        if (acc) begin
            p = cond_pass(in_cond, m_flags);
            q.push_back('{d: in_y, rd: in_rd, we: p});
            if (in_setf && p) m_flags = in_flags;
            if (p) m_exec = (m_exec < 65535) ? m_exec + 1 : m_exec;
            else   m_skip = (m_skip < 65535) ? m_skip + 1 : m_skip;
        end
        if (flush)                    m_ov = 1'b0;
        else if (acc)                 m_ov = 1'b1;
        else if (m_ov && out_ready)   m_ov = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [7:0] y, input logic [3:0] f, input logic [3:0] c,
                      input logic s, input logic [2:0] rd);
        in_valid = 1'b1;
        in_y     = y;
        in_flags = f;
        in_cond  = c;
        in_setf  = s;
        in_rd    = rd;
        step();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    logic [3:0] flag_set [6];

    initial begin
        n_checks = 0; n_pass = 0;
        m_ov = 1'b0; m_flags = 4'b0000; m_exec = 0; m_skip = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_y = '0; in_flags = '0; in_cond = '0;
        in_setf = 1'b0; in_rd = '0; flush = 1'b0; out_ready = 1'b1;
        flag_set = '{4'b0000, 4'b0101, 4'b1010, 4'b1111, 4'b0110, 4'b1001};

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", {24'b0, out_data}, 32'd0);
        check("rst_out_rd", {29'b0, out_rd}, 32'd0);
        check("rst_out_we", {31'b0, out_we}, 32'd0);
        check("rst_flags_q", {28'b0, flags_q}, 32'd0);
        rst_n = 1'b1;

        // Basic AL op with flag update
        op(8'h00, 4'b0001, 4'hE, 1'b1, 3'd2);
        idle(1);

        // Back-to-back dependency on freshly written flags
        op(8'h11, 4'b0001, 4'hE, 1'b1, 3'd1);
        op(8'h55, 4'b1111, 4'h0, 1'b0, 3'd3);
        op(8'h66, 4'b1111, 4'h1, 1'b1, 3'd4);
        idle(2);

        // Signed comparisons
        op(8'h01, 4'b1000, 4'hE, 1'b1, 3'd0);
        op(8'h02, 4'b0000, 4'hB, 1'b0, 3'd1);
        op(8'h03, 4'b1010, 4'hE, 1'b1, 3'd2);
        op(8'h04, 4'b0000, 4'hA, 1'b0, 3'd3);
        op(8'h05, 4'b0000, 4'hC, 1'b0, 3'd4);
        op(8'h06, 4'b1011, 4'hE, 1'b1, 3'd5);
        op(8'h07, 4'b0000, 4'hD, 1'b0, 3'd6);
        idle(2);

        // Full condition sweep across several flag patterns
        foreach (flag_set[k]) begin
            op(8'hA0 + 8'(k), flag_set[k], 4'hE, 1'b1, 3'd7);
            for (int c = 0; c < 16; c++)
                op(8'(c * 13 + k), ~flag_set[k], 4'(c), 1'b0, 3'(c));
        end
        idle(2);

        // Backpressure then release
        out_ready = 1'b0;
        op(8'hB1, 4'b0100, 4'hE, 1'b1, 3'd1);
        for (int i = 0; i < 3; i++) op(8'hB2, 4'b0010, 4'h2, 1'b1, 3'd2);
        out_ready = 1'b1;
        op(8'hB2, 4'b0010, 4'h2, 1'b1, 3'd2);
        op(8'hB3, 4'b0000, 4'h4, 1'b0, 3'd3);
        op(8'hB4, 4'b0001, 4'h5, 1'b1, 3'd4);
        idle(2);

        // Flush with a valid output and a pending input
        out_ready = 1'b0;
        op(8'hC1, 4'b1100, 4'hE, 1'b1, 3'd5);
        flush = 1'b1;
        op(8'hC2, 4'b0011, 4'hE, 1'b1, 3'd6);
        flush = 1'b0;
        out_ready = 1'b1;
        idle(2);

        // Asynchronous reset mid-stream
        op(8'hD1, 4'b0110, 4'hE, 1'b1, 3'd1);
        op(8'hD2, 4'b0111, 4'hE, 1'b1, 3'd2);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'b0, out_valid}, 32'd0);
        check("arst_flags_q", {28'b0, flags_q}, 32'd0);
        check("arst_out_data", {24'b0, out_data}, 32'd0);
`ifdef COND_WB_STATS_EN
        check("arst_exec_cnt", {16'b0, exec_cnt}, 32'd0);
        check("arst_skip_cnt", {16'b0, skip_cnt}, 32'd0);
`endif
        q.delete();
        m_ov = 1'b0; m_flags = 4'b0000; m_exec = 0; m_skip = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        op(8'hE1, 4'b0001, 4'hE, 1'b0, 3'd1);
        op(8'hE2, 4'b0010, 4'hE, 1'b0, 3'd2);
        op(8'hE3, 4'b0011, 4'hF, 1'b1, 3'd3);
        idle(3);
`ifdef COND_WB_STATS_EN
        check("final_exec_cnt", {16'b0, exec_cnt}, 32'd2);
        check("final_skip_cnt", {16'b0, skip_cnt}, 32'd1);
`endif
        check("sb_drained", q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_alu_cond_wb
`default_nettype wire
